// File: rtl/adma_as_pkg.sv
// Shared FSM states and flattened-bus slice helper for the ADMA AXI-slave-side scheduler.
`ifndef ADMA_AS_PKG_SV
`define ADMA_AS_PKG_SV

// Part-select of element idx (width w) in a flattened per-channel bus.
`define ADMA_AS_SLICE(idx, w) ((idx) * (w)) +: (w)

package adma_as_pkg;

    typedef enum logic [1:0] {
        SCHED_IDLE = 2'd0,
        SCHED_SEND = 2'd1,
        SCHED_WAIT = 2'd2
    } sched_state_e;

endpackage

`endif

// File: rtl/adma_as_rr_pick.sv
// Combinational cyclic first-one finder: first set bit of mask at or after start, with wrap.
module adma_as_rr_pick #(
    parameter int unsigned CHN_NUM = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [CHN_NUM-1:0] mask,
    input  logic [IDX_W-1:0]   start,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    int unsigned cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int unsigned k = 0; k < CHN_NUM; k++) begin
            cand = (32'(start) + k) % CHN_NUM;
            if (!found && mask[IDX_W'(cand)]) begin
                found = 1'b1;
                idx   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/adma_as_chn_sched.sv
// Channel scheduler: arbitrates DMA channels onto the single transaction request stage.
// ADMA_CHN_SCHED_WRR_EN selects weighted round-robin; otherwise plain round-robin.
module adma_as_chn_sched
    import adma_as_pkg::*;
#(
    parameter  int unsigned DMA_CHN_NUM   = 4,
    parameter  int unsigned DMA_CHN_ARB_W = 3,
    parameter  int unsigned DMA_LENGTH_W  = 16,
    parameter  int unsigned SRC_ADDR_W    = 32,
    parameter  int unsigned DST_ADDR_W    = 32,
    localparam int unsigned DMA_CHN_NUM_W = $clog2(DMA_CHN_NUM)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [DMA_CHN_NUM*SRC_ADDR_W-1:0]     chn_tx_src_addr,
    input  logic [DMA_CHN_NUM*DST_ADDR_W-1:0]     chn_tx_dst_addr,
    input  logic [DMA_CHN_NUM*DMA_LENGTH_W-1:0]   chn_tx_len,
    input  logic [DMA_CHN_NUM-1:0]                chn_tx_vld,
    output logic [DMA_CHN_NUM-1:0]                chn_tx_rdy,
    output logic [DMA_CHN_NUM-1:0]                chn_tx_done,
    input  logic [DMA_CHN_NUM*DMA_CHN_ARB_W-1:0]  chn_arb_rate,
    output logic [SRC_ADDR_W-1:0]                 tx_src_addr,
    output logic [DST_ADDR_W-1:0]                 tx_dst_addr,
    output logic [DMA_LENGTH_W-1:0]               tx_len,
    output logic                                  tx_vld,
    input  logic                                  tx_rdy,
    input  logic                                  tx_done,
    output logic                                  sched_busy,
    output logic [DMA_CHN_NUM_W-1:0]              sched_chn
);

    sched_state_e             state, state_nxt;
    logic [DMA_CHN_NUM_W-1:0] grant, grant_nxt;
    logic [DMA_CHN_NUM_W-1:0] ptr, ptr_nxt;
    logic [DMA_CHN_NUM_W-1:0] start;
    logic [DMA_CHN_NUM_W-1:0] pick_idx;
    logic                     pick_found;
    logic [DMA_CHN_NUM-1:0]   eligible;

    logic [SRC_ADDR_W-1:0]    src_arr  [DMA_CHN_NUM];
    logic [DST_ADDR_W-1:0]    dst_arr  [DMA_CHN_NUM];
    logic [DMA_LENGTH_W-1:0]  len_arr  [DMA_CHN_NUM];
    logic [DMA_CHN_ARB_W-1:0] rate_arr [DMA_CHN_NUM];

    // Unflatten per-channel buses; a zero weight masks the channel.
    for (genvar i = 0; i < DMA_CHN_NUM; i++) begin : g_chn
        assign src_arr[i]  = chn_tx_src_addr[`ADMA_AS_SLICE(i, SRC_ADDR_W)];
        assign dst_arr[i]  = chn_tx_dst_addr[`ADMA_AS_SLICE(i, DST_ADDR_W)];
        assign len_arr[i]  = chn_tx_len[`ADMA_AS_SLICE(i, DMA_LENGTH_W)];
        assign rate_arr[i] = chn_arb_rate[`ADMA_AS_SLICE(i, DMA_CHN_ARB_W)];
        assign eligible[i] = chn_tx_vld[i] && (rate_arr[i] != '0);
    end

    assign start = (ptr == DMA_CHN_NUM_W'(DMA_CHN_NUM - 1)) ? '0 : ptr + DMA_CHN_NUM_W'(1);

    adma_as_rr_pick #(
        .CHN_NUM (DMA_CHN_NUM),
        .IDX_W   (DMA_CHN_NUM_W)
    ) u_rr_pick (
        .mask  (eligible),
        .start (start),
        .found (pick_found),
        .idx   (pick_idx)
    );

`ifdef ADMA_CHN_SCHED_WRR_EN
    logic [DMA_CHN_ARB_W-1:0] credit, credit_nxt;
    logic                     regrant;

    assign regrant = (credit != '0) && eligible[ptr];
`endif

    assign tx_src_addr = src_arr[grant];
    assign tx_dst_addr = dst_arr[grant];
    assign tx_len      = len_arr[grant];
    assign sched_chn   = grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= SCHED_IDLE;
            grant  <= '0;
            ptr    <= DMA_CHN_NUM_W'(DMA_CHN_NUM - 1);
`ifdef ADMA_CHN_SCHED_WRR_EN
            credit <= '0;
`endif
        end else begin
            state  <= state_nxt;
            grant  <= grant_nxt;
            ptr    <= ptr_nxt;
`ifdef ADMA_CHN_SCHED_WRR_EN
            credit <= credit_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant;
        ptr_nxt     = ptr;
`ifdef ADMA_CHN_SCHED_WRR_EN
        credit_nxt  = credit;
`endif
        tx_vld      = 1'b0;
        sched_busy  = 1'b0;
        chn_tx_rdy  = '0;
        chn_tx_done = '0;

        case (state)
            SCHED_IDLE: begin
`ifdef ADMA_CHN_SCHED_WRR_EN
                if (regrant) begin
                    grant_nxt  = ptr;
                    credit_nxt = credit - DMA_CHN_ARB_W'(1);
                    state_nxt  = SCHED_SEND;
                end else if (pick_found) begin
                    grant_nxt  = pick_idx;
                    ptr_nxt    = pick_idx;
                    // Picked channel is eligible, so its weight is at least 1.
                    credit_nxt = rate_arr[pick_idx] - DMA_CHN_ARB_W'(1);
                    state_nxt  = SCHED_SEND;
                end
`else
                if (pick_found) begin
                    grant_nxt = pick_idx;
                    ptr_nxt   = pick_idx;
                    state_nxt = SCHED_SEND;
                end
`endif
            end
            SCHED_SEND: begin
                tx_vld            = 1'b1;
                sched_busy        = 1'b1;
                chn_tx_rdy[grant] = tx_rdy;
                if (tx_rdy) begin
                    state_nxt = SCHED_WAIT;
                end
            end
            SCHED_WAIT: begin
                sched_busy = 1'b1;
                if (tx_done) begin
                    chn_tx_done[grant] = 1'b1;
                    state_nxt          = SCHED_IDLE;
                end
            end
            default: begin
                state_nxt = SCHED_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_adma_as_chn_sched.sv
// Self-checking bench for adma_as_chn_sched; expectations adapt to ADMA_CHN_SCHED_WRR_EN.
`timescale 1ns/1ps
module tb_adma_as_chn_sched;

    localparam int unsigned N     = 4;
    localparam int unsigned ARB_W = 3;
    localparam int unsigned LEN_W = 16;
    localparam int unsigned SRC_W = 32;
    localparam int unsigned DST_W = 32;
    localparam int unsigned IDX_W = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [N*SRC_W-1:0]   chn_tx_src_addr;
    logic [N*DST_W-1:0]   chn_tx_dst_addr;
    logic [N*LEN_W-1:0]   chn_tx_len;
    logic [N-1:0]         chn_tx_vld;
    logic [N-1:0]         chn_tx_rdy;
    logic [N-1:0]         chn_tx_done;
    logic [N*ARB_W-1:0]   chn_arb_rate;
    logic [SRC_W-1:0]     tx_src_addr;
    logic [DST_W-1:0]     tx_dst_addr;
    logic [LEN_W-1:0]     tx_len;
    logic                 tx_vld;
    logic                 tx_rdy;
    logic                 tx_done;
    logic                 sched_busy;
    logic [IDX_W-1:0]     sched_chn;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    adma_as_chn_sched dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .chn_tx_src_addr (chn_tx_src_addr),
        .chn_tx_dst_addr (chn_tx_dst_addr),
        .chn_tx_len      (chn_tx_len),
        .chn_tx_vld      (chn_tx_vld),
        .chn_tx_rdy      (chn_tx_rdy),
        .chn_tx_done     (chn_tx_done),
        .chn_arb_rate    (chn_arb_rate),
        .tx_src_addr     (tx_src_addr),
        .tx_dst_addr     (tx_dst_addr),
        .tx_len          (tx_len),
        .tx_vld          (tx_vld),
        .tx_rdy          (tx_rdy),
        .tx_done         (tx_done),
        .sched_busy      (sched_busy),
        .sched_chn       (sched_chn)
    );

    function automatic logic [SRC_W-1:0] src_of(input int ch);
        return 32'hA000_0000 + 32'(ch) * 32'h10;
    endfunction

    function automatic logic [DST_W-1:0] dst_of(input int ch);
        return 32'hB000_0000 + 32'(ch) * 32'h100;
    endfunction

    function automatic logic [LEN_W-1:0] len_of(input int ch);
        return 16'h0040 + 16'(ch);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        chn_tx_vld = '0;
        tx_rdy     = 1'b0;
        tx_done    = 1'b0;
        exp_q.delete();
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic pop_exp(input string name, output int exp);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty when a grant appeared", name);
            exp = 0;
        end else begin
            exp = exp_q.pop_front();
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        chn_tx_vld = 4'b1111;
        tx_rdy     = 1'b1;
        tx_done    = 1'b1;
        tick();
        checks++; if (tx_vld !== 1'b0) begin errors++; $display("FAIL reset_tx_vld: got %b expected 0", tx_vld); end
        checks++; if (chn_tx_rdy !== 4'b0000) begin errors++; $display("FAIL reset_chn_tx_rdy: got %b expected 0000", chn_tx_rdy); end
        checks++; if (chn_tx_done !== 4'b0000) begin errors++; $display("FAIL reset_chn_tx_done: got %b expected 0000", chn_tx_done); end
        checks++; if (sched_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", sched_busy); end
        checks++; if (sched_chn !== 2'd0) begin errors++; $display("FAIL reset_sched_chn: got %0d expected 0", sched_chn); end
    endtask

    task automatic test_single_channel();
        int exp;
        do_reset();
        chn_arb_rate = {3'd1, 3'd1, 3'd1, 3'd1};
        tx_rdy       = 1'b1;
        chn_tx_vld   = 4'b0100;
        exp_q.push_back(2);
        #1;
        checks++; if (tx_vld !== 1'b0) begin errors++; $display("FAIL single_latency: tx_vld got %b expected 0 in request cycle", tx_vld); end
        tick();
        pop_exp("single", exp);
        checks++; if (tx_vld !== 1'b1) begin errors++; $display("FAIL single_tx_vld: got %b expected 1", tx_vld); end
        checks++; if (sched_chn !== IDX_W'(exp)) begin errors++; $display("FAIL single_chn: got %0d expected %0d", sched_chn, exp); end
        checks++; if (chn_tx_rdy !== N'(1 << exp)) begin errors++; $display("FAIL single_rdy: got %b expected %b", chn_tx_rdy, N'(1 << exp)); end
        checks++; if (tx_src_addr !== src_of(exp)) begin errors++; $display("FAIL single_src: got %h expected %h", tx_src_addr, src_of(exp)); end
        checks++; if (tx_dst_addr !== dst_of(exp)) begin errors++; $display("FAIL single_dst: got %h expected %h", tx_dst_addr, dst_of(exp)); end
        checks++; if (tx_len !== len_of(exp)) begin errors++; $display("FAIL single_len: got %h expected %h", tx_len, len_of(exp)); end
        tick();
        chn_tx_vld = '0;
        #1;
        checks++; if (tx_vld !== 1'b0 || chn_tx_rdy !== 4'b0000) begin errors++; $display("FAIL single_wait_outputs: tx_vld %b rdy %b expected 0 0000", tx_vld, chn_tx_rdy); end
        checks++; if (sched_busy !== 1'b1) begin errors++; $display("FAIL single_wait_busy: got %b expected 1", sched_busy); end
        checks++; if (chn_tx_done !== 4'b0000) begin errors++; $display("FAIL single_early_done: got %b expected 0000", chn_tx_done); end
        tick();
        tx_done = 1'b1;
        #1;
        checks++; if (chn_tx_done !== 4'b0100) begin errors++; $display("FAIL single_done: got %b expected 0100", chn_tx_done); end
        tick();
        tx_done = 1'b0;
        #1;
        checks++; if (chn_tx_done !== 4'b0000 || sched_busy !== 1'b0) begin errors++; $display("FAIL single_after_done: done %b busy %b expected 0000 0", chn_tx_done, sched_busy); end
        tx_done = 1'b1;
        #1;
        checks++; if (chn_tx_done !== 4'b0000) begin errors++; $display("FAIL stray_done_idle: got %b expected 0000", chn_tx_done); end
        tick();
        tx_done = 1'b0;
        checks++; if (sched_busy !== 1'b0) begin errors++; $display("FAIL stray_done_busy: got %b expected 0", sched_busy); end
    endtask

    // Serve n grants with tx_rdy high and an immediate done; checks order, descriptor and 2-cycle gap.
    task automatic run_grants(input string name, input int n);
        int exp;
        int waited;
        for (int g = 0; g < n; g++) begin
            waited = 0;
            while (tx_vld !== 1'b1 && waited < 8) begin
                tick();
                waited++;
            end
            checks++; if (waited !== 1) begin errors++; $display("FAIL %s_gap[%0d]: waited %0d cycles expected 1", name, g, waited); end
            pop_exp(name, exp);
            checks++; if (sched_chn !== IDX_W'(exp)) begin errors++; $display("FAIL %s_chn[%0d]: got %0d expected %0d", name, g, sched_chn, exp); end
            checks++; if (chn_tx_rdy !== N'(1 << exp)) begin errors++; $display("FAIL %s_rdy[%0d]: got %b expected %b", name, g, chn_tx_rdy, N'(1 << exp)); end
            checks++; if (tx_len !== len_of(exp)) begin errors++; $display("FAIL %s_len[%0d]: got %h expected %h", name, g, tx_len, len_of(exp)); end
            tick();
            tx_done = 1'b1;
            #1;
            checks++; if (chn_tx_done !== N'(1 << exp)) begin errors++; $display("FAIL %s_done[%0d]: got %b expected %b", name, g, chn_tx_done, N'(1 << exp)); end
            tick();
            tx_done = 1'b0;
        end
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL %s_leftover: %0d expected grants not seen", name, exp_q.size()); end
    endtask

    task automatic test_weighted();
        do_reset();
        chn_arb_rate = {3'd0, 3'd0, 3'd1, 3'd2};
        tx_rdy       = 1'b1;
`ifdef ADMA_CHN_SCHED_WRR_EN
        exp_q = '{0, 0, 1, 0, 0, 1};
`else
        exp_q = '{0, 1, 0, 1, 0, 1};
`endif
        chn_tx_vld = 4'b0011;
        run_grants("weight_2_1", 6);
        chn_tx_vld = '0;
    endtask

    task automatic test_weight_3_1();
        do_reset();
        chn_arb_rate = {3'd0, 3'd0, 3'd1, 3'd3};
        tx_rdy       = 1'b1;
`ifdef ADMA_CHN_SCHED_WRR_EN
        exp_q = '{0, 0, 0, 1, 0, 0, 0, 1};
`else
        exp_q = '{0, 1, 0, 1, 0, 1, 0, 1};
`endif
        chn_tx_vld = 4'b0011;
        run_grants("weight_3_1", 8);
        chn_tx_vld = '0;
    endtask

    task automatic test_masking();
        do_reset();
        chn_arb_rate = {3'd0, 3'd5, 3'd1, 3'd7};
        tx_rdy       = 1'b1;
        exp_q        = '{1, 1, 1, 1};
        chn_tx_vld   = 4'b1010;
        run_grants("mask", 4);
        chn_tx_vld = '0;
    endtask

    task automatic test_backpressure();
        int exp;
        int pulses;
        do_reset();
        chn_arb_rate = {3'd1, 3'd1, 3'd1, 3'd1};
        tx_rdy       = 1'b0;
        chn_tx_vld   = 4'b0010;
        exp_q.push_back(1);
        tick();
        pop_exp("bp", exp);
        for (int c = 0; c < 5; c++) begin
            checks++; if (tx_vld !== 1'b1 || sched_chn !== IDX_W'(exp)) begin errors++; $display("FAIL bp_hold[%0d]: tx_vld %b chn %0d expected 1 %0d", c, tx_vld, sched_chn, exp); end
            checks++; if (tx_src_addr !== src_of(exp) || tx_dst_addr !== dst_of(exp)) begin errors++; $display("FAIL bp_desc[%0d]: src %h dst %h expected %h %h", c, tx_src_addr, tx_dst_addr, src_of(exp), dst_of(exp)); end
            checks++; if (chn_tx_rdy !== 4'b0000) begin errors++; $display("FAIL bp_no_rdy[%0d]: got %b expected 0000", c, chn_tx_rdy); end
            tick();
        end
        tx_rdy = 1'b1;
        #1;
        checks++; if (chn_tx_rdy !== 4'b0010) begin errors++; $display("FAIL bp_release_rdy: got %b expected 0010", chn_tx_rdy); end
        pulses = (chn_tx_rdy != 4'b0000) ? 1 : 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chn_tx_vld = '0;
            #1;
            if (chn_tx_rdy != 4'b0000) pulses++;
        end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL bp_pulse_count: got %0d expected 1", pulses); end
        tx_done = 1'b1;
        #1;
        checks++; if (chn_tx_done !== 4'b0010) begin errors++; $display("FAIL bp_done: got %b expected 0010", chn_tx_done); end
        tick();
        tx_done = 1'b0;
    endtask

    task automatic test_reset_in_wait();
        int exp;
        do_reset();
        chn_arb_rate = {3'd1, 3'd1, 3'd1, 3'd1};
        tx_rdy       = 1'b1;
        chn_tx_vld   = 4'b1100;
        exp_q.push_back(2);
        tick();
        pop_exp("rst_wait", exp);
        checks++; if (sched_chn !== IDX_W'(exp)) begin errors++; $display("FAIL rst_wait_grant: got %0d expected %0d", sched_chn, exp); end
        tick();
        checks++; if (sched_busy !== 1'b1 || tx_vld !== 1'b0) begin errors++; $display("FAIL rst_wait_state: busy %b tx_vld %b expected 1 0", sched_busy, tx_vld); end
        rst_n   = 1'b0;
        tx_done = 1'b1;
        #1;
        checks++; if (tx_vld !== 1'b0 || sched_busy !== 1'b0) begin errors++; $display("FAIL rst_wait_abort: tx_vld %b busy %b expected 0 0", tx_vld, sched_busy); end
        checks++; if (sched_chn !== 2'd0) begin errors++; $display("FAIL rst_wait_chn: got %0d expected 0", sched_chn); end
        checks++; if (chn_tx_done !== 4'b0000 || chn_tx_rdy !== 4'b0000) begin errors++; $display("FAIL rst_wait_pulses: done %b rdy %b expected 0000 0000", chn_tx_done, chn_tx_rdy); end
        tick();
        tx_done = 1'b0;
        tick();
        chn_tx_vld = 4'b1110;
        rst_n      = 1'b1;
        exp_q.push_back(1);
        run_grants("post_reset", 1);
        chn_tx_vld = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n           = 1'b0;
        chn_tx_vld      = '0;
        tx_rdy          = 1'b0;
        tx_done         = 1'b0;
        chn_arb_rate    = '0;
        chn_tx_src_addr = {src_of(3), src_of(2), src_of(1), src_of(0)};
        chn_tx_dst_addr = {dst_of(3), dst_of(2), dst_of(1), dst_of(0)};
        chn_tx_len      = {len_of(3), len_of(2), len_of(1), len_of(0)};

        test_reset();
        test_single_channel();
        test_weighted();
        test_weight_3_1();
        test_masking();
        test_backpressure();
        test_reset_in_wait();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adma_as_chn_sched.md
# adma_as_chn_sched

Channel scheduler in front of the AXI-slave-side transaction request path. It picks one of `DMA_CHN_NUM` DMA channels using weighted round-robin, forwards that channel's transaction descriptor (source, destination, length) to the single transaction request stage, and routes completion back to the owning channel. One transaction is in flight at a time: a grant is held from issue until the downstream `tx_done`.

## Interface
- `DMA_CHN_NUM`, 4, number of DMA channels
- `DMA_CHN_ARB_W`, 3, per-channel weight width
- `DMA_LENGTH_W`, 16, transaction length width
- `SRC_ADDR_W`, 32, source address width
- `DST_ADDR_W`, 32, destination address width
- `DMA_CHN_NUM_W`, $clog2(DMA_CHN_NUM), channel index width (derived, not set by the user)
- `clk`  in  1  clock; the block uses one clock only
- `rst_n`  in  1  asynchronous, active-low reset
- `chn_tx_src_addr`  in  DMA_CHN_NUM*SRC_ADDR_W  per-channel source address; channel i occupies slice i
- `chn_tx_dst_addr`  in  DMA_CHN_NUM*DST_ADDR_W  per-channel destination address
- `chn_tx_len`  in  DMA_CHN_NUM*DMA_LENGTH_W  per-channel length
- `chn_tx_vld`  in  DMA_CHN_NUM  per-channel request valid
- `chn_tx_rdy`  out  DMA_CHN_NUM  per-channel accept (one-hot pulse)
- `chn_tx_done`  out  DMA_CHN_NUM  per-channel completion (one-hot pulse)
- `chn_arb_rate`  in  DMA_CHN_NUM*DMA_CHN_ARB_W  per-channel weight; 0 means the channel is masked
- `tx_src_addr`  out  SRC_ADDR_W  to the request stage
- `tx_dst_addr`  out  DST_ADDR_W  to the request stage
- `tx_len`  out  DMA_LENGTH_W  to the request stage
- `tx_vld`  out  1  descriptor valid
- `tx_rdy`  in  1  request stage accepts the descriptor
- `tx_done`  in  1  single-cycle pulse: the granted transaction has finished
- `sched_busy`  out  1  high in SEND and WAIT
- `sched_chn`  out  DMA_CHN_NUM_W  index of the granted channel

## Operation
- FSM with three states: IDLE, SEND, WAIT.
- **IDLE**: if any channel is eligible (`chn_tx_vld[i]` is high and its weight is non-zero), register the grant and go to SEND. If no channel is eligible, stay in IDLE.
- **Grant selection**, where `ptr` is the last granted channel:
  - If `credit` > 0, `ptr` is eligible, and `ptr` still has a non-zero weight: regrant `ptr` and decrement `credit`.
  - Otherwise: search `ptr+1`, `ptr+2`, … cyclically, with wrap-around mod `DMA_CHN_NUM`, for the first eligible channel. Grant it, set `ptr` to it, and load `credit` = weight − 1.
  - The weight is sampled only when `credit` is loaded.
- **SEND**: `tx_*` are a combinational mux of the granted channel's slices. `tx_vld` = 1. `chn_tx_rdy[g]` = `tx_rdy`. On the handshake, go to WAIT.
- **WAIT**: on `tx_done`, `chn_tx_done[g]` = 1 in the same cycle, then return to IDLE.
- A channel must hold its `vld` and descriptor stable from raising `vld` until its `rdy`. The grant is not revoked if `vld` drops during this window; that is a protocol violation.
- A `tx_done` outside WAIT is ignored.
- Arithmetic: `credit` is `DMA_CHN_ARB_W` bits wide and never underflows.

## Timing
- Reset values:
  - `tx_vld`, `chn_tx_rdy`, `chn_tx_done`, `sched_busy` = 0
  - `sched_chn` = 0
  - state = IDLE, `ptr` = DMA_CHN_NUM−1, `credit` = 0. The first search therefore starts at channel 0.
- Latency: an eligible request in IDLE at cycle N gives `tx_vld` = 1 at cycle N+1. If `tx_rdy` is already high, the handshake completes at N+1.
- While `tx_rdy` is low in SEND, `tx_vld`, `tx_*` and `sched_chn` stay stable.
- `tx_done` at cycle M → state is IDLE at M+1 → next grant is issued at M+2. Minimum gap between two grants: 2 cycles after `tx_done`.
- `tx_done` and a new `chn_tx_vld` in the same cycle: the done is serviced first; the new request is arbitrated in IDLE.
- Asserting `rst_n` in SEND or WAIT aborts immediately: all outputs go to their reset values, and the in-flight grant is dropped without any `chn_tx_done`.

## Configuration
- `ADMA_CHN_SCHED_WRR_EN` defined: weighted round-robin as described above.
- Not defined: plain round-robin.
  - `credit` logic is removed; every grant searches from `ptr+1`.
  - A weight of 0 still masks the channel; any non-zero weight is treated as 1.

## Structure
- Shared package `adma_as_pkg` holds:
  - FSM state localparams: `SCHED_IDLE`, `SCHED_SEND`, `SCHED_WAIT`
  - slice-index helper macros for the flattened per-channel buses
- One sub-module, `adma_as_rr_pick`: combinational cyclic first-one finder.
  - Inputs: eligibility mask, start index.
  - Outputs: found flag, found index.

## Test plan
- Single channel: `chn_tx_vld[2]`, `tx_rdy` = 1 → `tx_vld` 1 cycle later with channel 2's descriptor and `sched_chn` = 2. `chn_tx_rdy` = 0100. After `tx_done`, `chn_tx_done` = 0100 for one cycle.
- WRR: channels 0 and 1 request continuously with weights 2 and 1 → grant order 0,0,1,0,0,1.
- Masking: channel 3 with weight 0 requests alongside channel 1 with weight 1 → only channel 1 is ever granted; channel 3 receives no `chn_tx_rdy`.
- Backpressure: hold `tx_rdy` low for 5 cycles in SEND → `tx_*` and `sched_chn` stable, no `chn_tx_rdy`. Release `tx_rdy` → exactly one `chn_tx_rdy` pulse.
- Reset in WAIT: assert `rst_n` low → outputs at reset values, no `chn_tx_done`. After release, the first grant goes to the lowest eligible channel.
- Without `ADMA_CHN_SCHED_WRR_EN`: channels 0 and 1 with weights 3 and 1 → grant order 0,1,0,1.
